// File: rtl/ifetch_prefetch_q.sv
// Instruction-fetch front end: owns the PC, streams word reads from a synchronous ROM into a
// prefetch queue, and hands {pc, instr, pc+4} to decode. Optional counters under IFETCH_PERF_EN.
module ifetch_prefetch_q #(
  parameter int                ADDR_W   = 32,
  parameter int                IMEM_AW  = 14,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] PC_LIMIT = 32'h0000_FFFC
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inited,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  out_link,
  output logic               halted,
  output logic [1:0]         state_dbg
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] tag_q;

  logic [ADDR_W-1:0] q_pc    [DEPTH];
  logic [31:0]       q_instr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;

  logic [CNT_W:0]    occupancy;
  logic              credit_ok;
  logic              pc_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic              flush;
  logic              head_valid;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^redirect_addr[1:0];

  // Credit rule: queued entries plus the one possible in-flight read never exceed DEPTH,
  // so every issued read is guaranteed a slot and the queue cannot overflow.
  assign occupancy = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign credit_ok = occupancy < (CNT_W+1)'(DEPTH);
  assign pc_ok     = pc_q <= PC_LIMIT;

  assign issue = (state_q == S_FETCH) && inited && !redirect_valid && credit_ok && pc_ok;
  assign flush = redirect_valid || !inited;
  assign push  = inflight_q && !flush;

  // Handshake: out_valid means the head entry is a real instruction; it is consumed on any
  // cycle where out_valid && out_ready, and out_valid never depends on out_ready.
  assign head_valid = (count_q != '0);
  assign pop        = head_valid && out_ready;

  assign imem_en   = issue;
  assign imem_addr = pc_q[IMEM_AW+1:2];

  assign out_valid = head_valid;
  assign out_pc    = head_valid ? q_pc[rd_ptr_q] : '0;
  assign out_instr = head_valid ? q_instr[rd_ptr_q] : '0;
  assign out_link  = head_valid ? (q_pc[rd_ptr_q] + ADDR_W'(4)) : '0;
  assign halted    = (state_q == S_HALT);
  assign state_dbg = state_q;

  // Control: FSM, PC, in-flight tracking and queue pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      if (!inited) begin
        state_q <= S_IDLE;
        pc_q    <= RESET_PC;
      end else if (redirect_valid) begin
        state_q <= S_FETCH;
        pc_q    <= {redirect_addr[ADDR_W-1:2], 2'b00};
      end else begin
        case (state_q)
          S_IDLE:  state_q <= S_FETCH;
          S_FETCH: begin
            if (issue) begin
              pc_q <= pc_q + ADDR_W'(4);
            end else if (!pc_ok) begin
              state_q <= S_HALT;
            end
          end
          S_HALT:  state_q <= S_HALT;
          default: state_q <= S_IDLE;
        endcase
      end

      inflight_q <= issue;
      if (issue) begin
        tag_q <= pc_q;
      end

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Queue storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr_q]    <= tag_q;
      q_instr[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (redirect_valid && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_prefetch_q.sv
// Bench for ifetch_prefetch_q: ROM model returns its word address, scoreboard holds expected PCs.
module tb_ifetch_prefetch_q;

  logic        clock;
  logic        reset;
  logic        inited;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_link;
  logic        halted;
  logic [1:0]  state_dbg;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  ifetch_prefetch_q dut (
    .clock          (clock),
    .reset          (reset),
    .inited         (inited),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_link       (out_link),
    .halted         (halted),
    .state_dbg      (state_dbg)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  // Clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  // ROM model: word i holds value i, read one cycle after the strobe.
  always @(posedge clock) begin
    if (imem_en) imem_rdata <= {18'b0, imem_addr};
  end

  // Scoreboard: every accepted instruction is compared with the oldest expected PC.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got pc=%h, required no output", out_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (out_pc !== e || out_instr !== (e >> 2) || out_link !== e + 32'd4) begin
          n_bad++;
          $display("FAIL stream: got pc=%h instr=%h link=%h, required pc=%h instr=%h link=%h",
                   out_pc, out_instr, out_link, e, e >> 2, e + 32'd4);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d entries left, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_redirect(input logic [31:0] addr);
    step();
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    inited = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr = '0;
    repeat (3) step();
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || out_link !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_out: got v=%b pc=%h instr=%h link=%h, required all 0",
               out_valid, out_pc, out_instr, out_link);
    end
    n_cmp++;
    if (imem_en !== 1'b0 || halted !== 1'b0 || state_dbg !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got en=%b halted=%b state=%0d, required 0 0 0",
               imem_en, halted, state_dbg);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    push_exp(32'h0, 16);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() == 16 && k < 20) begin
      step();
      k++;
    end
    repeat (15) step();
    out_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_throughput: %0d left after 16 cycles, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_backpressure();
    int en_cnt;
    en_cnt = 0;
    do_redirect(32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (imem_en) en_cnt++;
      step();
    end
    @(negedge clock);
    n_cmp++;
    if (en_cnt != 4) begin
      n_bad++;
      $display("FAIL bp_issue_count: got %0d, required 4", en_cnt);
    end
    n_cmp++;
    if (imem_en !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_full: got en=%b v=%b, required en=0 v=1", imem_en, out_valid);
    end
    push_exp(32'h0, 6);
    step();
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_release_gap: %0d left after 6 cycles, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_redirect();
    repeat (8) step();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_t1: got v=%b, required 0", out_valid);
    end
    step();
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL redir_t2: got v=%b, required 0", out_valid);
    end
    step();
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h40) begin
      n_bad++;
      $display("FAIL redir_t3: got v=%b pc=%h instr=%h, required 1 00000100 00000040",
               out_valid, out_pc, out_instr);
    end
    // Second redirect lands while a read of 0x108 is in flight.
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0200;
    step();
    redirect_valid = 1'b0;
    push_exp(32'h200, 3);
    drain("redir", 30);
  endtask

  task automatic test_halt();
    do_redirect(32'h0000_FFF8);
    repeat (10) step();
    @(negedge clock);
    n_cmp++;
    if (halted !== 1'b1 || imem_en !== 1'b0 || out_valid !== 1'b1 || state_dbg !== 2'd2) begin
      n_bad++;
      $display("FAIL halt_state: got halted=%b en=%b v=%b state=%0d, required 1 0 1 2",
               halted, imem_en, out_valid, state_dbg);
    end
    push_exp(32'h0000_FFF8, 2);
    drain("halt", 10);
    repeat (3) step();
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || halted !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_drained: got v=%b halted=%b, required 0 1", out_valid, halted);
    end
    do_redirect(32'h0);
    @(negedge clock);
    n_cmp++;
    if (halted !== 1'b0 || imem_en !== 1'b1 || imem_addr !== 14'h0) begin
      n_bad++;
      $display("FAIL halt_resume: got halted=%b en=%b addr=%h, required 0 1 0000",
               halted, imem_en, imem_addr);
    end
    push_exp(32'h0, 2);
    drain("resume", 20);
  endtask

  task automatic test_inited();
    repeat (6) step();
    inited = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (imem_en !== 1'b0) begin
      n_bad++;
      $display("FAIL inited_en_now: got %b, required 0", imem_en);
    end
    step();
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || imem_en !== 1'b0) begin
      n_bad++;
      $display("FAIL inited_low: got v=%b en=%b, required 0 0", out_valid, imem_en);
    end
    repeat (3) step();
    @(negedge clock);
    n_cmp++;
    if (state_dbg !== 2'd0 || imem_en !== 1'b0) begin
      n_bad++;
      $display("FAIL inited_idle: got state=%0d en=%b, required 0 0", state_dbg, imem_en);
    end
    step();
    inited = 1'b1;
    push_exp(32'h0, 3);
    drain("inited", 30);
  endtask

  task automatic test_reset_mid();
    repeat (3) step();
    reset = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0000_0400;
    step();
    reset = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0 || out_link !== 32'h0 ||
        halted !== 1'b0 || imem_en !== 1'b0 || state_dbg !== 2'd0) begin
      n_bad++;
      $display("FAIL midreset_out: got v=%b pc=%h instr=%h link=%h halted=%b en=%b state=%0d, required all 0",
               out_valid, out_pc, out_instr, out_link, halted, imem_en, state_dbg);
    end
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0) begin
      n_bad++;
      $display("FAIL perf_reset: got fetch=%0d flush=%0d, required 0 0", perf_fetch_cnt, perf_flush_cnt);
    end
    step();
    redirect_valid = 1'b1;
    redirect_addr  = 32'h0;
    step();
    step();
    redirect_valid = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (perf_flush_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL perf_flush: got %0d, required 2", perf_flush_cnt);
    end
`endif
    push_exp(32'h0, 3);
    drain("midreset", 30);
`ifdef IFETCH_PERF_EN
    n_cmp++;
    if (perf_fetch_cnt < 32'd3) begin
      n_bad++;
      $display("FAIL perf_fetch: got %0d, required at least 3", perf_fetch_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_redirect();
    test_halt();
    test_inited();
    test_reset_mid();
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
